// File: rtl/ifr_pkg.sv
// ----------------------------------------------------------------------------
// ifr_pkg
// Shared definitions for the instruction fetch register:
//   ifr_state_e        - fetch sequencer states
//   OPERAND_COUNT      - 2-bit operand count per opcode, entry i at [2*i +: 2]
//   OPCODE_TABLE_SIZE  - number of entries in OPERAND_COUNT
// ----------------------------------------------------------------------------
package ifr_pkg;

    typedef enum logic [1:0] {
        FETCH_OP  = 2'd0,
        FETCH_ARG = 2'd1,
        DONE      = 2'd2
    } ifr_state_e;

    localparam int OPCODE_TABLE_SIZE = 16;

    // Operand counts, opcode 15 down to 0:
    //   F:3 E:2 D:1 C:0 B:3 A:2 9:1 8:0 7:3 6:2 5:1 4:3 3:1 2:2 1:0 0:0
    // Entries of 3 exceed the default MAX_OPERANDS and are saturated by the
    // decoder.
    localparam logic [2*OPCODE_TABLE_SIZE-1:0] OPERAND_COUNT = 32'hE4E4_E760;

endpackage

// File: rtl/ifr_len_decode.sv
// ----------------------------------------------------------------------------
// ifr_len_decode
// Combinational opcode -> operand-count lookup, saturated to MAX_OPERANDS.
// Ports:
//   opcode : in  [OPCODE_BITS-1:0]  opcode to look up
//   len    : out [LEN_W-1:0]        number of operand bytes that follow
// Opcodes beyond the table decode to zero operands.
// ----------------------------------------------------------------------------
module ifr_len_decode
    import ifr_pkg::*;
#(
    parameter int OPCODE_BITS  = 4,
    parameter int MAX_OPERANDS = 2,
    parameter int LEN_W        = $clog2(MAX_OPERANDS + 1)
) (
    input  logic [OPCODE_BITS-1:0] opcode,
    output logic [LEN_W-1:0]       len
);

    logic [1:0] raw_len;

    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        raw_len = 2'd0;
        for (int i = 0; i < OPCODE_TABLE_SIZE; i++) begin
            if (int'(opcode) == i) begin
                raw_len = OPERAND_COUNT[2*i +: 2];
            end
        end
    end

    always_comb begin
        if (int'(raw_len) > MAX_OPERANDS) begin
            len = LEN_W'(MAX_OPERANDS);
        end else begin
            len = LEN_W'(raw_len);
        end
    end

endmodule

// File: rtl/instr_fetch_register.sv
// ----------------------------------------------------------------------------
// instr_fetch_register
// Assembles a variable-length instruction (opcode byte + 0..MAX_OPERANDS
// operand bytes) from a shared bus, one byte per read_from_bus strobe.
// Ports:
//   clk, rst       : clock; asynchronous active-high reset
//   clear          : synchronous abort of the current instruction (data kept)
//   read_from_bus  : capture bus_in into the next byte slot
//   write_to_bus   : drive (byte 0 & BUS_MASK) onto bus_out, else 0
//   bus_in         : shared bus data
//   bus_out        : masked byte 0 when enabled
//   opcode         : upper OPCODE_BITS of byte 0
//   operand        : operand byte k at [k*WIDTH +: WIDTH]
//   value          : raw byte 0
//   instr_valid    : a complete instruction is held
//   byte_index     : next slot to fill (0 when waiting for an opcode)
// ----------------------------------------------------------------------------
module instr_fetch_register
    import ifr_pkg::*;
#(
    parameter int               WIDTH        = 8,
    parameter int               OPCODE_BITS  = 4,
    parameter int               MAX_OPERANDS = 2,
    parameter logic [WIDTH-1:0] BUS_MASK     = WIDTH'(8'h0F),
    localparam int              IDX_W        = $clog2(MAX_OPERANDS + 1),
    localparam int              OPS_W        = WIDTH * MAX_OPERANDS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   read_from_bus,
    input  logic                   write_to_bus,
    input  logic [WIDTH-1:0]       bus_in,
    output logic [WIDTH-1:0]       bus_out,
    output logic [OPCODE_BITS-1:0] opcode,
    output logic [OPS_W-1:0]       operand,
    output logic [WIDTH-1:0]       value,
    output logic                   instr_valid,
    output logic [IDX_W-1:0]       byte_index
);

    ifr_state_e       state_q, state_d;
    logic [WIDTH-1:0] byte0_q, byte0_d;
    logic [OPS_W-1:0] ops_q,   ops_d;
    logic [IDX_W-1:0] idx_q,   idx_d;

    // Length of the instruction whose opcode is arriving on the bus now.
    logic [IDX_W-1:0] new_len;
    // Length of the instruction currently held in byte 0.
    logic [IDX_W-1:0] cur_len;

    ifr_len_decode #(
        .OPCODE_BITS  (OPCODE_BITS),
        .MAX_OPERANDS (MAX_OPERANDS)
    ) u_new_len (
        .opcode (bus_in[WIDTH-1 -: OPCODE_BITS]),
        .len    (new_len)
    );

    ifr_len_decode #(
        .OPCODE_BITS  (OPCODE_BITS),
        .MAX_OPERANDS (MAX_OPERANDS)
    ) u_cur_len (
        .opcode (byte0_q[WIDTH-1 -: OPCODE_BITS]),
        .len    (cur_len)
    );

    always_comb begin
        state_d = state_q;
        byte0_d = byte0_q;
        ops_d   = ops_q;
        idx_d   = idx_q;

        if (clear) begin
            // Abort wins over a simultaneous read; captured bytes stay visible.
            state_d = FETCH_OP;
            idx_d   = '0;
        end else if (read_from_bus) begin
            case (state_q)
                FETCH_OP, DONE: begin
                    // DONE accepts the next opcode directly: no idle cycle.
                    byte0_d = bus_in;
                    ops_d   = '0;
                    if (new_len == '0) begin
                        state_d = DONE;
                        idx_d   = '0;
                    end else begin
                        state_d = FETCH_ARG;
                        idx_d   = IDX_W'(1);
                    end
                end
                FETCH_ARG: begin
                    // Slot idx_q holds operand idx_q-1.
                    for (int k = 0; k < MAX_OPERANDS; k++) begin
                        if (int'(idx_q) == k + 1) begin
                            ops_d[k*WIDTH +: WIDTH] = bus_in;
                        end
                    end
                    if (idx_q == cur_len) begin
                        state_d = DONE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                default: begin
                    state_d = FETCH_OP;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH_OP;
            byte0_q <= '0;
            ops_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            byte0_q <= byte0_d;
            ops_q   <= ops_d;
            idx_q   <= idx_d;
        end
    end

    // bus_out is combinational from the registered byte 0, so a same-cycle
    // read shows the pre-edge value.
    assign bus_out     = write_to_bus ? (byte0_q & BUS_MASK) : '0;
    assign opcode      = byte0_q[WIDTH-1 -: OPCODE_BITS];
    assign operand     = ops_q;
    assign value       = byte0_q;
    assign instr_valid = (state_q == DONE);
    assign byte_index  = idx_q;

endmodule

// File: tb/tb_instr_fetch_register.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch_register
// Directed stimulus against a transaction-level model of the fetch register:
// the model tracks "waiting for opcode / collecting operands / complete" and
// fills byte arrays; a compare process checks every output after each edge.
// ----------------------------------------------------------------------------
module tb_instr_fetch_register;

    localparam int W  = 8;
    localparam int OB = 4;
    localparam int MO = 2;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clear = 1'b0;
    logic          read_from_bus = 1'b0;
    logic          write_to_bus = 1'b0;
    logic [W-1:0]  bus_in = '0;
    logic [W-1:0]  bus_out;
    logic [OB-1:0] opcode;
    logic [W*MO-1:0] operand;
    logic [W-1:0]  value;
    logic          instr_valid;
    logic [IW-1:0] byte_index;

    instr_fetch_register dut (
        .clk           (clk),
        .rst           (rst),
        .clear         (clear),
        .read_from_bus (read_from_bus),
        .write_to_bus  (write_to_bus),
        .bus_in        (bus_in),
        .bus_out       (bus_out),
        .opcode        (opcode),
        .operand       (operand),
        .value         (value),
        .instr_valid   (instr_valid),
        .byte_index    (byte_index)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    int         len_tab [16] = '{0, 0, 2, 1, 3, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
    logic [7:0] m_byte0;
    logic [7:0] m_ops [MO];
    int         m_len;
    int         m_pos;      // operands captured so far
    bit         m_active;   // collecting operands
    bit         m_valid;
    bit         cmp_en = 1'b0;

    task automatic model_reset();
        m_byte0  = 8'h00;
        for (int i = 0; i < MO; i++) m_ops[i] = 8'h00;
        m_len    = 0;
        m_pos    = 0;
        m_active = 1'b0;
        m_valid  = 1'b0;
    endtask

    task automatic model_step(input bit r, input bit c, input logic [7:0] d);
        if (c) begin
            m_active = 1'b0;
            m_valid  = 1'b0;
        end else if (r) begin
            if (!m_active) begin
                m_byte0 = d;
                for (int i = 0; i < MO; i++) m_ops[i] = 8'h00;
                m_len = len_tab[d[7:4]];
                if (m_len > MO) m_len = MO;
                m_pos = 0;
                if (m_len == 0) begin
                    m_valid = 1'b1;
                end else begin
                    m_active = 1'b1;
                    m_valid  = 1'b0;
                end
            end else begin
                m_ops[m_pos] = d;
                m_pos++;
                if (m_pos == m_len) begin
                    m_active = 1'b0;
                    m_valid  = 1'b1;
                end
            end
        end
    endtask

    // Compare all outputs against the model 2 time units after each edge.
    always @(posedge clk) begin
        #2;
        if (cmp_en && !rst) begin
            check("cmp_value",  32'(value), 32'(m_byte0));
            check("cmp_opcode", 32'(opcode), 32'(m_byte0[7:4]));
            check("cmp_operand", 32'(operand), 32'({m_ops[1], m_ops[0]}));
            check("cmp_valid",  32'(instr_valid), 32'(m_valid));
            check("cmp_index",  32'(byte_index), m_active ? 32'(m_pos + 1) : 32'd0);
            check("cmp_bus_out", 32'(bus_out), write_to_bus ? 32'(m_byte0 & 8'h0F) : 32'd0);
        end
    end

    // One clock: drive at negedge, check pre-edge bus_out, step model at the
    // edge, return 3 units after the edge.
    task automatic cycle(input bit r, input bit w, input bit c, input logic [7:0] d);
        @(negedge clk);
        read_from_bus = r;
        write_to_bus  = w;
        clear         = c;
        bus_in        = d;
        #1;
        check("bus_out_pre", 32'(bus_out), w ? 32'(m_byte0 & 8'h0F) : 32'd0);
        @(posedge clk);
        model_step(r, c, d);
        #3;
    endtask

    initial begin
        model_reset();
        #1 rst = 1'b1;
        #2;
        check("rst_value",   32'(value), 32'h0);
        check("rst_operand", 32'(operand), 32'h0);
        check("rst_valid",   32'(instr_valid), 32'h0);
        check("rst_index",   32'(byte_index), 32'h0);
        @(negedge clk);
        rst    = 1'b0;
        cmp_en = 1'b1;

        // Opcode 1, no operands.
        cycle(1, 0, 0, 8'h1E);
        check("op1_opcode", 32'(opcode), 32'h1);
        check("op1_valid",  32'(instr_valid), 32'h1);
        check("op1_value",  32'(value), 32'h1E);
        cycle(0, 1, 0, 8'h00);
        check("op1_bus_out", 32'(bus_out), 32'h0E);

        // Opcode 2, two operands, back to back from DONE.
        cycle(1, 0, 0, 8'h20);
        check("op2_idx1",   32'(byte_index), 32'h1);
        check("op2_valid1", 32'(instr_valid), 32'h0);
        cycle(1, 0, 0, 8'hAA);
        check("op2_idx2",   32'(byte_index), 32'h2);
        check("op2_valid2", 32'(instr_valid), 32'h0);
        cycle(1, 0, 0, 8'h55);
        check("op2_idx0",    32'(byte_index), 32'h0);
        check("op2_valid3",  32'(instr_valid), 32'h1);
        check("op2_operand", 32'(operand), 32'h55AA);
        cycle(0, 0, 0, 8'h00);
        check("op2_hold", 32'(operand), 32'h55AA);

        // New opcode from DONE clears operands.
        cycle(1, 0, 0, 8'h1F);
        check("op1b_operand", 32'(operand), 32'h0);
        check("op1b_valid",   32'(instr_valid), 32'h1);
        check("op1b_opcode",  32'(opcode), 32'h1);

        // clear beats read_from_bus, data kept.
        cycle(1, 0, 0, 8'h20);
        cycle(1, 0, 1, 8'hAA);
        check("clr_valid", 32'(instr_valid), 32'h0);
        check("clr_index", 32'(byte_index), 32'h0);
        check("clr_value", 32'(value), 32'h20);
        cycle(1, 0, 0, 8'h1E);
        check("clr_next_valid", 32'(instr_valid), 32'h1);

        // Saturation: opcode 4 lists 3 operands, capped at 2.
        cycle(1, 0, 0, 8'h4F);
        cycle(1, 0, 0, 8'h11);
        cycle(1, 0, 0, 8'h22);
        check("sat_valid",   32'(instr_valid), 32'h1);
        check("sat_operand", 32'(operand), 32'h2211);

        // Asynchronous reset in the middle of FETCH_ARG.
        cycle(1, 0, 0, 8'h20);
        @(negedge clk);
        read_from_bus = 1'b0;
        clear         = 1'b0;
        write_to_bus  = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("arst_value",   32'(value), 32'h0);
        check("arst_operand", 32'(operand), 32'h0);
        check("arst_valid",   32'(instr_valid), 32'h0);
        check("arst_index",   32'(byte_index), 32'h0);
        check("arst_opcode",  32'(opcode), 32'h0);
        check("arst_bus_out", 32'(bus_out), 32'h0);
        #1 rst = 1'b0;
        model_reset();
        cycle(1, 0, 0, 8'h1E);
        check("arst_next_valid", 32'(instr_valid), 32'h1);

        // Same-cycle read and write: byte 0 = 3C parked in FETCH_OP via clear.
        cycle(1, 0, 0, 8'h3C);
        cycle(0, 0, 1, 8'h00);
        cycle(1, 1, 0, 8'h47);
        check("rw_bus_out_next", 32'(bus_out), 32'h07);

        cycle(0, 0, 0, 8'h00);
        cycle(0, 0, 0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_register.md
INSTR_FETCH_REGISTER -- requirements
Module: instr_fetch_register

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bus and byte width in bits.
REQ-002 SHALL have parameter OPCODE_BITS, default 4, opcode field taken from the MSBs of the first byte.
REQ-003 SHALL have parameter MAX_OPERANDS, default 2, the maximum number of extra operand bytes per instruction.
REQ-004 SHALL have parameter BUS_MASK, default 8'h0F, the mask applied to byte 0 when it is driven to the bus.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port clear, input, 1 bit: synchronous abort of the current instruction.
REQ-008 SHALL have port read_from_bus, input, 1 bit: capture bus_in into the next byte slot.
REQ-009 SHALL have port write_to_bus, input, 1 bit: drive masked byte 0 onto bus_out.
REQ-010 SHALL have port bus_in, input, WIDTH bits: shared bus data.
REQ-011 SHALL have port bus_out, output, WIDTH bits: masked byte 0 when enabled, else 0.
REQ-012 SHALL have port opcode, output, OPCODE_BITS bits: the upper bits of byte 0.
REQ-013 SHALL have port operand, output, WIDTH*MAX_OPERANDS bits: operand byte k at bits [k*WIDTH +: WIDTH].
REQ-014 SHALL have port value, output, WIDTH bits: raw byte 0.
REQ-015 SHALL have port instr_valid, output, 1 bit: high while a complete instruction is held.
REQ-016 SHALL have port byte_index, output, $clog2(MAX_OPERANDS+1) bits: index of the next slot to fill.

Function
REQ-017 SHALL implement the states FETCH_OP, FETCH_ARG and DONE.
REQ-018 In FETCH_OP, read_from_bus SHALL capture bus_in into byte 0, zero all operand bytes, and look up len = operand count(opcode); len==0 -> DONE, else -> FETCH_ARG with byte_index=1.
REQ-019 In FETCH_ARG, read_from_bus SHALL capture bus_in into operand byte byte_index-1 and increment byte_index; the capture of byte len -> DONE.
REQ-020 In DONE, read_from_bus SHALL behave exactly as in FETCH_OP, so back-to-back instructions need no idle cycle.
REQ-021 Without read_from_bus or clear, all state and data SHALL hold.
REQ-022 instr_valid SHALL be 1 only in DONE; the cycle after the final capture it is 1 (one-cycle latency).
REQ-023 bus_out SHALL be combinational: write_to_bus ? (byte 0 & BUS_MASK) : 0.
REQ-024 With read_from_bus and write_to_bus in the same cycle, bus_out SHALL show the pre-edge byte 0.
REQ-025 clear SHALL take priority over read_from_bus: next state FETCH_OP, byte_index 0, instr_valid 0, data bytes unchanged.
REQ-026 A len greater than MAX_OPERANDS SHALL be saturated to MAX_OPERANDS.
REQ-027 byte_index SHALL never exceed MAX_OPERANDS; it SHALL be 0 in FETCH_OP and DONE.

Reset
REQ-028 rst high SHALL immediately set state FETCH_OP, byte 0 = 0, all operands = 0, byte_index = 0 and instr_valid = 0, regardless of clk.
REQ-029 A reset in the middle of an instruction SHALL discard the partial instruction; the first read after reset is treated as an opcode.

Structure
REQ-030 A shared package ifr_pkg SHALL hold the state enum type and the OPERAND_COUNT table (2 bits per opcode, indexed by opcode).
REQ-031 The lookup SHALL be a sub-module ifr_len_decode (opcode in -> saturated len out), combinational only.

Verification
REQ-032 Reset, then read 8'h1E with opcode 1 and len 0 -> next cycle opcode=1, instr_valid=1, value=8'h1E; write_to_bus -> bus_out=8'h0E.
REQ-033 Opcode 2 with len 2: read 8'h20, 8'hAA, 8'h55 on consecutive cycles -> operand=16'h55AA, byte_index 0->1->2->0, instr_valid=1 only after the third capture.
REQ-034 After REQ-033, read 8'h1F -> operand=0, instr_valid stays 1, opcode=1.
REQ-035 Read 8'h20 then assert clear together with read_from_bus -> state FETCH_OP, instr_valid=0, byte 0 still 8'h20.
REQ-036 Pulse rst asynchronously between clock edges during FETCH_ARG -> all outputs 0 before the next edge; write_to_bus -> bus_out=0.
REQ-037 Assert read_from_bus and write_to_bus together with byte 0 = 8'h3C and bus_in=8'h47 -> bus_out=8'h0C that cycle, 8'h07 the next.
